// File: rtl/twofish_q_perm.sv
// Twofish q0/q1 byte permutations with a single registered output stage.
// Both permutations share one nibble-mixing structure and differ only in their tables.
module twofish_q_perm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x,
  input  logic       valid_in,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic       valid_out
);

  // Tables packed with index 0 in the most significant nibble, matching written order.
  localparam logic [63:0] Q0T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1T3 = 64'hB951C3DE647F208A;

  function automatic logic [3:0] tbl_lookup(input logic [63:0] tbl, input logic [3:0] idx);
    logic [5:0] base;
    base = {~idx, 2'b00};
    return tbl[base +: 4];
  endfunction

  // b-side mix: a ^ ROR4(b,1) ^ ((8*a) mod 16)
  function automatic logic [3:0] mix_b(input logic [3:0] a, input logic [3:0] b);
    return a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
  endfunction

  function automatic logic [7:0] q_perm(input logic [7:0]  v,
                                        input logic [63:0] t0,
                                        input logic [63:0] t1,
                                        input logic [63:0] t2,
                                        input logic [63:0] t3);
    logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
    a1 = v[7:4] ^ v[3:0];
    b1 = mix_b(v[7:4], v[3:0]);
    a2 = tbl_lookup(t0, a1);
    b2 = tbl_lookup(t1, b1);
    a3 = a2 ^ b2;
    b3 = mix_b(a2, b2);
    a4 = tbl_lookup(t2, a3);
    b4 = tbl_lookup(t3, b3);
    return {b4, a4};
  endfunction

  logic [7:0] y0_d, y0_q;
  logic [7:0] y1_d, y1_q;
  logic       valid_d, valid_q;

  always_comb begin
    y0_d    = y0_q;
    y1_d    = y1_q;
    valid_d = valid_in;
    if (valid_in) begin
      y0_d = q_perm(x, Q0T0, Q0T1, Q0T2, Q0T3);
      y1_d = q_perm(x, Q1T0, Q1T1, Q1T2, Q1T3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q    <= 8'h00;
      y1_q    <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      valid_q <= valid_d;
    end
  end

  assign y0        = y0_q;
  assign y1        = y1_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_twofish_q_perm.sv
// Scoreboard bench for twofish_q_perm: reset, known vectors, hold, sweep with
// mid-stream reset, and a bijection count on both outputs.
module tb_twofish_q_perm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] x;
  logic       valid_in;
  logic [7:0] y0, y1;
  logic       valid_out;

  always #5 clk = ~clk;

  twofish_q_perm u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .valid_in (valid_in),
    .y0       (y0),
    .y1       (y1),
    .valid_out(valid_out)
  );

  typedef struct packed {
    logic [7:0] y0;
    logic [7:0] y1;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] last_y0 = 8'h00;
  logic [7:0] last_y1 = 8'h00;
  bit         seen0[256];
  bit         seen1[256];
  logic [3:0] tq[0:1][0:3][0:15];

  initial begin
    tq[0][0] = '{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4};
    tq[0][1] = '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD};
    tq[0][2] = '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1};
    tq[0][3] = '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA};
    tq[1][0] = '{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5};
    tq[1][1] = '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8};
    tq[1][2] = '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF};
    tq[1][3] = '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA};
  end

  function automatic int ror1(input int v);
    return ((v >> 1) | (v << 3)) & 15;
  endfunction

  function automatic logic [7:0] ref_q(input int sel, input logic [7:0] v);
    int a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = int'(v) / 16;
    b0 = int'(v) % 16;
    a1 = a0 ^ b0;
    b1 = (a0 ^ ror1(b0) ^ ((8 * a0) % 16)) & 15;
    a2 = int'(tq[sel][0][a1]);
    b2 = int'(tq[sel][1][b1]);
    a3 = a2 ^ b2;
    b3 = (a2 ^ ror1(b2) ^ ((8 * a2) % 16)) & 15;
    a4 = int'(tq[sel][2][a3]);
    b4 = int'(tq[sel][3][b3]);
    return 8'(b4 * 16 + a4);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y0"}, 16'(y0), 16'h00);
    check({tag, "_y1"}, 16'(y1), 16'h00);
    check({tag, "_vo"}, 16'(valid_out), 16'h0);
  endtask

  // One cycle: drive on negedge, push expectation at the sampling edge, compare 1 ns later.
  task automatic step(input logic v, input logic [7:0] xin);
    exp_t e;
    @(negedge clk);
    valid_in = v;
    x        = xin;
    @(posedge clk);
    if (v) sb.push_back({ref_q(0, xin), ref_q(1, xin)});
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("vout_hi", 16'(valid_out), 16'h1);
      check("y0", 16'(y0), 16'(e.y0));
      check("y1", 16'(y1), 16'(e.y1));
      seen0[y0] = 1'b1;
      seen1[y1] = 1'b1;
      last_y0 = e.y0;
      last_y1 = e.y1;
    end else begin
      check("vout_lo", 16'(valid_out), 16'h0);
      check("hold_y0", 16'(y0), 16'(last_y0));
      check("hold_y1", 16'(y1), 16'(last_y1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1;
    rst_n    = 1'b0;
    valid_in = 1'b1;
    x        = 8'h5A;
    #1;
    check_zero("rst_init");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x = (i % 2 == 0) ? 8'hA5 : 8'h5A;
      #1;
      check_zero("rst_neg");
      @(posedge clk);
      #1;
      check_zero("rst_pos");
    end
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst_n = 1'b1;
    step(1'b0, 8'h00);

    // Known vectors and hold behaviour.
    step(1'b1, 8'h00);
    check("kv00_y0", 16'(y0), 16'hA9);
    check("kv00_y1", 16'(y1), 16'h75);
    step(1'b1, 8'h01);
    check("kv01_y0", 16'(y0), 16'h67);
    check("kv01_y1", 16'(y1), 16'hF3);
    step(1'b1, 8'h00);
    step(1'b0, 8'hFF);
    check("hold_kv_y0", 16'(y0), 16'hA9);
    check("hold_kv_y1", 16'(y1), 16'h75);
    step(1'b0, 8'hFF);

    // Exhaustive sweep with an asynchronous reset pulse part way through.
    for (int i = 0; i < 256; i++) begin
      seen0[i] = 1'b0;
      seen1[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        @(negedge clk);
        valid_in = 1'b1;
        x        = 8'(i);
        #2 rst_n = 1'b0;
        #1;
        check_zero("mid_rst_async");
        sb.delete();
        @(posedge clk);
        #1;
        check_zero("mid_rst_held");
        @(negedge clk);
        valid_in = 1'b0;
        #1 rst_n = 1'b1;
        last_y0 = 8'h00;
        last_y1 = 8'h00;
        step(1'b0, 8'h00);
      end
      step(1'b1, 8'(i));
    end
    step(1'b0, 8'h00);

    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 256; i++) begin
      cnt0 += int'(seen0[i]);
      cnt1 += int'(seen1[i]);
    end
    check("bij_y0", 16'(cnt0), 16'd256);
    check("bij_y1", 16'(cnt1), 16'd256);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
